instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage directly upstream of the instruction memory and downstream-facing to decode. Holds the program counter and drives it as the byte address to the combinational instruction memory. Captures each returned word with its PC into a small in-order buffer, presented to decode over a valid/ready handshake. Supports control-flow redirect with flush, and halts fetch on the all-zero word that terminates a program image.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `DEPTH`, 2: buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instructionAddress`  out  32  byte address to instruction memory; equals PC register.
- `instruction`  in  32  word returned combinationally by memory for `instructionAddress`, same cycle.
- `redirectValid`  in  1  take redirect this cycle.
- `redirectTarget`  in  32  new PC; bits [1:0] forced to 0.
- `outValid`  out  1  buffer head valid.
- `outReady`  in  1  decode accepts head when `outValid && outReady`.
- `outPC`  out  32  PC of head entry.
- `outInstruction`  out  32  instruction word of head entry.
- `halted`  out  1  fetch stopped on zero word.

## Operation
- States: FETCH, HALT. Reset → FETCH.
- Registers: `pc`, `count` (0..DEPTH), read and write pointers, DEPTH×{pc, instruction} storage, state.
- `pop` = `outValid && outReady`. `space` = `count < DEPTH || pop`.
- Priority per edge, highest first:
  1. Redirect. If `redirectValid`: the head is consumed if `pop` (the accepted handshake stands). All entries are discarded, so `count` becomes 0. `pc <= {redirectTarget[31:2], 2'b00}`. State becomes FETCH. No push this cycle. Applies in both states.
  2. Zero word. FETCH, `instruction == 32'h0`, `space`: no push. `pc` holds. State becomes HALT.
  3. Push. FETCH, `space`, nonzero word: write {pc, instruction} at the tail. `pc <= pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  4. Stall. FETCH, no `space`: `pc` holds and nothing is written. The zero-word check applies only when `space`.
- `pop` without redirect: the read pointer advances. Push and pop in the same cycle leave `count` unchanged.
- HALT: no pushes; `pc` holds the address of the zero word. Existing entries continue to drain normally. HALT exits only by redirect or reset.
- Outputs:
  - `outValid = (count != 0)`.
  - `outPC` / `outInstruction` = head storage entry, stable while `outValid && !outReady`.
  - `halted = (state == HALT)`.
- Reset values, applied immediately on `rst_n` low:
  - `pc = RESET_PC`, so `instructionAddress = RESET_PC`.
  - `count = 0`, pointers 0, storage 0.
  - `outValid = 0`, `outPC = 0`, `outInstruction = 0`, `halted = 0`, state FETCH.

## Timing
- Memory read is combinational: the word for `pc` is sampled at the same edge that advances `pc`.
- Fetch-to-decode latency: 1 cycle. The word at address A, fetched at edge n, appears on `outValid` after edge n.
- Throughput: 1 instruction/cycle with `outReady` high and the buffer not full. A full buffer with a pop in the same cycle still pushes, so there is no bubble.
- Redirect: `outValid` is 0 for exactly the cycle after the redirect edge. The target's entry is valid after the following edge.
- Halt: `halted` rises after the edge that sampled the zero word. After a redirect edge it falls in the same cycle that `outValid` drops.
- Reset deassertion: the first fetch happens at the first rising edge with `rst_n` high.

## Test plan
- Program image with 0x00100093@0, 0x00200113@4, 0x401111B3@8, 0@12; `outReady` = 1 after reset: outputs (0, 0x00100093), (4, 0x00200113), (8, 0x401111B3) on consecutive cycles. `halted` = 1 after the edge sampling address 12; `instructionAddress` holds 12.
- Same image, `outReady` = 0 for 5 cycles after reset: `count` reaches 2, `instructionAddress` = 8, `outPC` stays 0. Then `outReady` = 1: 0, 4, 8 delivered in order with no loss or duplicate, then halt.
- While halted, redirect to 0x0000_0006: PC becomes 4. `halted` = 0 and `outValid` = 0 the next cycle. Then (4, 0x00200113), (8, 0x401111B3), then halt again.
- Redirect to 0 asserted in the same cycle as a pop with 2 entries buffered: the head counts as consumed and the second entry never appears. `outValid` = 0 for one cycle, then (0, 0x00100093).
- `rst_n` pulled low between edges mid-stream: `outValid`, `halted` and `outPC` go to 0 and `instructionAddress` goes to `RESET_PC` immediately, without a clock edge.
- Bench drives `instruction` = 0x00000013 for all addresses; redirect to 0xFFFF_FFFC: outputs PC 0xFFFF_FFFC, then 0x0000_0000, 0x0000_0004 (wrap-around).

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads a combinational instruction memory, and queues
// {pc, word} pairs in a small in-order buffer for decode; halts on an all-zero word.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instruction,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outPC,
  output logic [31:0] outInstruction,
  output logic        halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [31:0]       pc_r, pc_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [31:0]       pc_mem_r    [DEPTH];
  logic [31:0]       instr_mem_r [DEPTH];
  logic              pop_s, space_s, push_s, flush_s;

  assign outValid           = (count_r != {CNT_W{1'b0}});
  assign outPC              = pc_mem_r[rd_ptr_r];
  assign outInstruction     = instr_mem_r[rd_ptr_r];
  assign halted             = (state_r == HALT);
  assign instructionAddress = pc_r;

  assign pop_s   = outValid && outReady;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign space_s = (count_r < DEPTH_C) || pop_s;

  // Next-state, next-PC and push/flush decision, redirect taking priority.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    if (redirectValid) begin
      flush_s     = 1'b1;
      pc_nxt_s    = redirectTarget & 32'hFFFF_FFFC;
      state_nxt_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (space_s) begin
            if (instruction == 32'h0000_0000) begin
              state_nxt_s = HALT;
            end else begin
              push_s   = 1'b1;
              pc_nxt_s = pc_r + 32'd4;
            end
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        HALT: begin
          state_nxt_s = HALT;
        end
        default: begin
          state_nxt_s = FETCH;
        end
      endcase
    end
  end

  // PC, state, buffer pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      state_r  <= FETCH;
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
      if (flush_s) begin
        count_r  <= {CNT_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          pc_mem_r[wr_ptr_r]    <= pc_r;
          instr_mem_r[wr_ptr_r] <= instruction;
          wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1'b1);
          2'b01:   count_r <= count_r - CNT_W'(1'b1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
